// File: rtl/mdu_pkg.sv
// Shared types and constants for the iterative multiply/divide sequencer.
package mdu_pkg;

  localparam int   MDU_WIDTH = 32;
  localparam logic OP_MULT   = 1'b0;
  localparam logic OP_DIV    = 1'b1;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    FIX  = 2'd2,
    DONE = 2'd3
  } mdu_state_t;

endpackage

// File: rtl/mult_div_seq.sv
// Iterative signed multiply / divide: WIDTH shift-add or restoring shift-subtract
// steps on operand magnitudes, then a sign-fix cycle and a one-cycle done pulse.
module mult_div_seq
  import mdu_pkg::*;
#(
  parameter int WIDTH = MDU_WIDTH
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             start,
  input  logic             op,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  output logic             busy,
  output logic             done,
  output logic             div_zero,
  output logic [WIDTH-1:0] hi,
  output logic [WIDTH-1:0] lo
);

  localparam int CW = $clog2(WIDTH);

  mdu_state_t         state_q, state_d;
  logic [CW-1:0]      cnt_q, cnt_d;
  logic [2*WIDTH-1:0] acc_q, acc_d;
  logic [WIDTH-1:0]   opnd_q, opnd_d;
  logic [WIDTH-1:0]   hi_q, hi_d;
  logic [WIDTH-1:0]   lo_q, lo_d;
  logic               op_q, op_d;
  logic               neg_res_q, neg_res_d;
  logic               neg_rem_q, neg_rem_d;
  logic               dz_q, dz_d;

  logic [WIDTH-1:0]   abs_a, abs_b;
  logic [WIDTH:0]     add_sum, prem, diff;
  logic [2*WIDTH-1:0] mult_next, div_next, prod;
  logic [WIDTH-1:0]   quo, rem;

  // Negating -2^(W-1) wraps back to itself, which is its correct unsigned magnitude.
  assign abs_a = a[WIDTH-1] ? -a : a;
  assign abs_b = b[WIDTH-1] ? -b : b;

  // Mult: acc = {partial product, remaining multiplier bits}; add keeps its carry.
  assign add_sum   = {1'b0, acc_q[2*WIDTH-1:WIDTH]} + (acc_q[0] ? {1'b0, opnd_q} : '0);
  assign mult_next = {add_sum, acc_q[WIDTH-1:1]};

  // Div: acc = {remainder, dividend bits shifting out / quotient bits shifting in}.
  assign prem     = acc_q[2*WIDTH-1:WIDTH-1];
  assign diff     = prem - {1'b0, opnd_q};
  assign div_next = diff[WIDTH] ? {prem[WIDTH-1:0], acc_q[WIDTH-2:0], 1'b0}
                                : {diff[WIDTH-1:0], acc_q[WIDTH-2:0], 1'b1};

  assign prod = neg_res_q ? -acc_q : acc_q;
  assign quo  = acc_q[WIDTH-1:0];
  assign rem  = acc_q[2*WIDTH-1:WIDTH];

  always_comb begin
    state_d   = state_q;
    cnt_d     = cnt_q;
    acc_d     = acc_q;
    opnd_d    = opnd_q;
    hi_d      = hi_q;
    lo_d      = lo_q;
    op_d      = op_q;
    neg_res_d = neg_res_q;
    neg_rem_d = neg_rem_q;
    dz_d      = dz_q;
    case (state_q)
      IDLE: begin
        if (start) begin
          op_d = op;
          if (op == OP_DIV && b == '0) begin
            dz_d    = 1'b1;
            state_d = DONE;
          end else begin
            state_d   = RUN;
            opnd_d    = (op == OP_MULT) ? abs_a : abs_b;
            acc_d     = (op == OP_MULT) ? {{WIDTH{1'b0}}, abs_b} : {{WIDTH{1'b0}}, abs_a};
            neg_res_d = a[WIDTH-1] ^ b[WIDTH-1];
            neg_rem_d = a[WIDTH-1];
            cnt_d     = CW'(WIDTH - 1);
            dz_d      = 1'b0;
          end
        end
      end
      RUN: begin
        acc_d = (op_q == OP_DIV) ? div_next : mult_next;
        cnt_d = cnt_q - 1'b1;
        if (cnt_q == '0) state_d = FIX;
      end
      FIX: begin
        if (op_q == OP_DIV) begin
          lo_d = neg_res_q ? -quo : quo;
          hi_d = neg_rem_q ? -rem : rem;
        end else begin
          hi_d = prod[2*WIDTH-1:WIDTH];
          lo_d = prod[WIDTH-1:0];
        end
        state_d = DONE;
      end
      DONE: begin
        state_d = IDLE;
        dz_d    = 1'b0;
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q   <= IDLE;
      cnt_q     <= '0;
      acc_q     <= '0;
      opnd_q    <= '0;
      hi_q      <= '0;
      lo_q      <= '0;
      op_q      <= 1'b0;
      neg_res_q <= 1'b0;
      neg_rem_q <= 1'b0;
      dz_q      <= 1'b0;
    end else begin
      state_q   <= state_d;
      cnt_q     <= cnt_d;
      acc_q     <= acc_d;
      opnd_q    <= opnd_d;
      hi_q      <= hi_d;
      lo_q      <= lo_d;
      op_q      <= op_d;
      neg_res_q <= neg_res_d;
      neg_rem_q <= neg_rem_d;
      dz_q      <= dz_d;
    end
  end

  assign busy     = (state_q == RUN) || (state_q == FIX);
  assign done     = (state_q == DONE);
  assign div_zero = (state_q == DONE) && dz_q;
  assign hi       = hi_q;
  assign lo       = lo_q;

endmodule

// File: tb/tb_mult_div_seq.sv
// Directed-vector bench for mult_div_seq: latency, busy window, results, div-by-zero,
// ignored restarts and asynchronous reset mid-operation.
module tb_mult_div_seq;

  logic        clk;
  logic        reset;
  logic        start;
  logic        op;
  logic [31:0] a;
  logic [31:0] b;
  logic        busy;
  logic        done;
  logic        div_zero;
  logic [31:0] hi;
  logic [31:0] lo;

  int n_checks = 0;
  int n_pass   = 0;

  mult_div_seq #(.WIDTH(32)) dut (
    .clk      (clk),
    .reset    (reset),
    .start    (start),
    .op       (op),
    .a        (a),
    .b        (b),
    .busy     (busy),
    .done     (done),
    .div_zero (div_zero),
    .hi       (hi),
    .lo       (lo)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_checks++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
  endtask

  // Issues one operation, watches 40 cycles after the accept edge, and checks
  // done cycle/count, busy length and the results captured in the done cycle.
  // inj > 0 pulses a stray start (div by zero) in that cycle.
  task automatic run_op(input string name, input logic op_v, input logic [31:0] a_v,
                        input logic [31:0] b_v, input logic [31:0] exp_hi,
                        input logic [31:0] exp_lo, input logic exp_dz,
                        input int exp_cyc, input int inj);
    int done_cnt = 0;
    int done_cyc = 0;
    int busy_cnt = 0;
    logic [31:0] got_hi = 32'hx;
    logic [31:0] got_lo = 32'hx;
    logic got_dz = 1'bx;
    @(negedge clk);
    start = 1'b1; op = op_v; a = a_v; b = b_v;
    for (int cyc = 1; cyc <= 40; cyc++) begin
      @(negedge clk);
      if (done) begin
        done_cnt++;
        if (done_cnt == 1) begin
          done_cyc = cyc; got_hi = hi; got_lo = lo; got_dz = div_zero;
        end
      end
      if (busy) busy_cnt++;
      start = (cyc == inj);
      op    = 1'b1;
      a     = $urandom;
      b     = 32'd0;
    end
    $display("%s: a=0x%08h b=0x%08h -> hi=0x%08h lo=0x%08h dz=%0d done@%0d dones=%0d busy=%0d",
             name, a_v, b_v, got_hi, got_lo, got_dz, done_cyc, done_cnt, busy_cnt);
    check({name, "/done_cycle"}, 64'(done_cyc), 64'(exp_cyc));
    check({name, "/done_count"}, 64'(done_cnt), 64'd1);
    check({name, "/busy_cycles"}, 64'(busy_cnt), exp_dz ? 64'd0 : 64'(exp_cyc - 1));
    check({name, "/hi"}, 64'(got_hi), 64'(exp_hi));
    check({name, "/lo"}, 64'(got_lo), 64'(exp_lo));
    check({name, "/div_zero"}, 64'(got_dz), 64'(exp_dz));
  endtask

  initial begin
    int dones;
    reset = 1'b1; start = 1'b0; op = 1'b0; a = '0; b = '0;
    #3 reset = 1'b0;
    repeat (2) @(negedge clk);
    $display("reset: busy=%0d done=%0d dz=%0d hi=0x%08h lo=0x%08h", busy, done, div_zero, hi, lo);
    check("reset/busy", 64'(busy), 64'd0);
    check("reset/done", 64'(done), 64'd0);
    check("reset/div_zero", 64'(div_zero), 64'd0);
    check("reset/hi", 64'(hi), 64'd0);
    check("reset/lo", 64'(lo), 64'd0);
    reset = 1'b1;

    run_op("mult_7_m3", 1'b0, 32'd7, 32'hFFFF_FFFD, 32'hFFFF_FFFF, 32'hFFFF_FFEB, 1'b0, 34, 0);
    run_op("mult_min_min", 1'b0, 32'h8000_0000, 32'h8000_0000, 32'h4000_0000, 32'h0, 1'b0, 34, 0);
    run_op("div_m7_2", 1'b1, 32'hFFFF_FFF9, 32'd2, 32'hFFFF_FFFF, 32'hFFFF_FFFD, 1'b0, 34, 0);
    run_op("div_min_m1", 1'b1, 32'h8000_0000, 32'hFFFF_FFFF, 32'h0, 32'h8000_0000, 1'b0, 34, 0);
    run_op("div_451_20", 1'b1, 32'h451, 32'h20, 32'h11, 32'h22, 1'b0, 34, 0);
    run_op("div_5_0", 1'b1, 32'd5, 32'd0, 32'h11, 32'h22, 1'b1, 1, 0);
    run_op("mult_restart", 1'b0, 32'd1000, 32'hFFFF_FF9C, 32'hFFFF_FFFF, 32'hFFFE_7960, 1'b0, 34, 10);

    // Reset in cycle 15 of a divide: outputs clear immediately, no done follows.
    @(negedge clk);
    start = 1'b1; op = 1'b1; a = 32'd100; b = 32'd7;
    @(negedge clk);
    start = 1'b0;
    repeat (13) @(negedge clk);
    #2 reset = 1'b0;
    #1;
    $display("reset_mid_div: busy=%0d done=%0d hi=0x%08h lo=0x%08h", busy, done, hi, lo);
    check("reset_mid/busy", 64'(busy), 64'd0);
    check("reset_mid/done", 64'(done), 64'd0);
    check("reset_mid/hi", 64'(hi), 64'd0);
    check("reset_mid/lo", 64'(lo), 64'd0);
    repeat (2) @(negedge clk);
    reset = 1'b1;
    dones = 0;
    repeat (40) begin
      @(negedge clk);
      if (done) dones++;
    end
    $display("after_reset_idle: dones=%0d", dones);
    check("reset_mid/no_done", 64'(dones), 64'd0);

    run_op("mult_6_7", 1'b0, 32'd6, 32'd7, 32'h0, 32'd42, 1'b0, 34, 0);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
